// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one fixed-latency memory port between instruction fetch and load/store.
// Accept-to-valid is LATENCY+1 cycles; a requester sees ready low while any access is in flight.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;

  logic idle;
  logic grant_i;
  logic grant_d;
  logic last_cycle;

  // On contention the side that did not win last time is granted.
  assign idle       = (state_q == S_IDLE);
  assign grant_i    = idle && i_req && (!d_req || (last_owner_q == OWN_D));
  assign grant_d    = idle && d_req && (!i_req || (last_owner_q == OWN_I));
  assign last_cycle = !idle && (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_valid_d    = 1'b0;
    d_valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_i) begin
          state_d      = S_BUSY_I;
          cnt_d        = CNT_LOAD;
          last_owner_d = OWN_I;
          addr_d       = i_addr;
        end else if (grant_d) begin
          state_d      = S_BUSY_D;
          cnt_d        = CNT_LOAD;
          last_owner_d = OWN_D;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          we_d         = d_we;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (last_cycle) begin
          state_d = S_IDLE;
          if (state_q == S_BUSY_I) begin
            i_rdata_d = mem_dout;
            i_valid_d = 1'b1;
          end else begin
            if (!we_q) begin
              d_rdata_d = mem_dout;
            end
            d_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_owner_q <= OWN_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_valid_q    <= i_valid_d;
      d_valid_q    <= d_valid_d;
    end
  end

  // A store pulses the write strobe only in its first busy cycle (count still at its load value).
  assign mem_read  = (state_q == S_BUSY_I) || ((state_q == S_BUSY_D) && !we_q);
  assign mem_write = (state_q == S_BUSY_D) && we_q && (cnt_q == CNT_LOAD);
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;

  assign i_ready = grant_i;
  assign d_ready = grant_d;
  assign i_valid = i_valid_q;
  assign d_valid = d_valid_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = !idle;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single fixed-latency memory port of the multi-cycle RISC-V core between the instruction-fetch requester and the load/store requester. Each access is accepted with a req/ready handshake, driven onto the memory for a fixed LATENCY cycles from latched registers, and answered with a one-cycle valid pulse on the owning side. It sits between the control unit's fetch/memory phases and the unified memory model, so the control unit never drives memory address or strobes directly.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 4, memory cycles per access (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ready
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  fetch accepted this cycle
- i_valid  out  1  fetch data valid (one-cycle pulse)
- i_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  data request accepted this cycle
- d_valid  out  1  load data / store done (one-cycle pulse)
- d_rdata  out  DATA_W  load data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data, valid in last access cycle
- busy  out  1  access in flight

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Registers: owner addr/wdata/we latches, down-counter cnt (width clog2(LATENCY+1)), last_owner bit, i_rdata, d_rdata.
- IDLE: if exactly one req high, grant it. If both high, grant the side not equal to last_owner (round-robin). last_owner resets to DATA, so the first contention goes to fetch.
- Grant: i_ready/d_ready is combinational, high only in IDLE for the granted side. On that edge: latch address (and d_we, d_wdata), cnt <= LATENCY-1, last_owner <= granted side, state <= BUSY_I or BUSY_D.
- BUSY_x: mem_addr = latched address; mem_read = 1 every BUSY cycle for reads; for stores mem_write = 1 only in the first BUSY cycle, mem_din = latched wdata. cnt decrements each cycle. When cnt == 0: state <= IDLE; for reads, capture mem_dout into i_rdata/d_rdata; assert the owner's valid registered for the next cycle.
- Stores: d_valid pulses as completion; d_rdata unchanged.
- i_rdata/d_rdata hold their last value until the next read on that side.
- A req dropped before ready is simply not accepted; no state change.
- Requests arriving while busy wait, with no ready, and are arbitrated in the next IDLE cycle.
- In IDLE, mem_read = mem_write = 0; mem_addr/mem_din hold the last latched values.
- busy = (state != IDLE).

## Timing
- Reset (reset = 0, asynchronous) forces: state IDLE, cnt 0, last_owner DATA, all latches 0, i_rdata = d_rdata = 0. Every output is 0 during and after reset until a request arrives.
- Reset mid-access aborts it: strobes drop immediately and no valid pulse follows.
- Accept at edge T (ready high in cycle T) gives BUSY in cycles T+1 … T+LATENCY. Valid is high in cycle T+LATENCY+1, which is also an IDLE cycle.
- In that same cycle a pending request may see ready, so back-to-back throughput is one access per LATENCY+1 cycles.
- LATENCY = 1: a single BUSY cycle in which cnt is already 0.
- ready and valid of the same side may be high in the same cycle (new accept while the previous response is presented).

## Test plan
- Fetch after reset, LATENCY=4: i_req=1, i_addr=0x10, memory returns 0x00500093 → i_ready in cycle 0, mem_read high cycles 1–4 with mem_addr=0x10, i_valid in cycle 5 with i_rdata=0x00500093, busy low in cycle 5.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_write high only in cycle 1, mem_read never high, d_valid in cycle 5, d_rdata unchanged.
- Contention: i_req and d_req held high from reset → grants alternate I, D, I, D with ready spaced 5 cycles apart; each valid lands on the correct side with the correct data.
- Hold-off: d_req raised during a fetch BUSY → d_ready stays low until the IDLE cycle after the fetch, then fires with the original d_addr.
- Reset mid-access: assert reset in cycle 2 of a load → mem_read drops asynchronously, no d_valid ever appears, and the next request completes normally.
- LATENCY=1 build: load from 0x4 returning 0x1234 → mem_read for exactly one cycle, d_valid 2 cycles after accept, d_rdata=0x1234.
